instr_stream_encoder: RTL and testbench
=======================================

// Module: instr_stream_encoder
// PURPOSE
//  Inverse of the instruction decoders: packs decoded fields (group, opcode, reg indices, immediates) into 16-bit instruction words.
//  Streams the words with consecutive addresses to a memory write port; sits between the test-program loader/debug port and instruction RAM.
//  Groups 1-4 emit one word; group 5 emits two words (hi, then the 16-bit imm).
// PARAMETERS
//  ADDR_W  16  width of out_addr; address counter wraps modulo 2**ADDR_W
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset_n      in   1       asynchronous active-low reset
//  in_valid     in   1       field bundle valid
//  in_ready     out  1       encoder accepts bundle this cycle
//  in_group     in   3       1..5 = instr group; 0,6,7 = unknown
//  in_opcode    in   6       opcode, LSBs used per group (g1:3 g2:6 g3:2 g4:4 g5:3)
//  in_ra        in   4       ra index (pair number when in_ra_pair)
//  in_rb        in   4       rb index (g2), or rbp in [2:0] (g3, g5)
//  in_rc        in   3       rcp index (g3)
//  in_imm       in   16      g1/g4: [7:0]; g5: full second word
//  in_ra_pair   in   1       ra is a pair index: field = {in_ra[2:0],1'b0}
//  in_rb_pair   in   1       rb is a pair index (g2 only): field = {in_rb[2:0],1'b0}
//  load_addr    in   1       load address counter
//  load_value   in   ADDR_W  new address
//  out_valid    out  1       write word valid
//  out_ready    in   1       memory accepts word
//  out_addr     out  ADDR_W  write address
//  out_data     out  16      encoded word
//  out_last     out  1       word completes an instruction
//  err_group    out  1       one-cycle pulse: unknown group accepted and dropped
// BEHAVIOUR
//  Encodings, MSB first:
//   g1 0ooo aaaa iiii iiii; g2 10oo oooo aaaa bbbb; g3 1100 ooaa aabb bccc
//   g4 1101 oooo iiii iiii; g5 1110 00oo oaaa abbb + iiii iiii iiii iiii
//  Pair shift: in_ra_pair honoured for g1, g2, g5; ignored for g3. Index bit 3 dropped.
//  Reset: state EMPTY, out_valid=0, out_data=0, out_addr=0, out_last=0, err_group=0.
//  FSM: EMPTY (no word held), W0 (single or first word held), W1 (g5 imm word held).
//  in_ready = EMPTY | (W0 & out_ready & ~g5_pending) | (W1 & out_ready).
//  Accept (in_valid & in_ready), known group: next cycle out_valid=1, out_data=word0.
//   g5: state W0 with g5_pending, imm latched.
//   else: out_last=1, state W0.
//  Latency: encoded word appears on the cycle after acceptance. Throughput: 1 word/cycle with out_ready held high.
//  Handshake: out_data/out_addr/out_last stay stable while out_valid & ~out_ready.
//  Transfer (out_valid & out_ready): out_addr increments, wrapping from 2**ADDR_W-1 to 0.
//   W0 & g5_pending -> W1: out_data=imm, out_last=1.
//   Otherwise -> EMPTY, or -> W0 if a new bundle is accepted the same cycle.
//  Unknown group: accepted, no word emitted, addr unchanged, err_group=1 next cycle.
//  load_addr is honoured only when state EMPTY and no bundle is accepted that cycle; it is ignored otherwise.
//  Reset mid-g5 (W0 or W1): pending imm word discarded, counter back to 0.
//  in_valid while in_ready=0: bundle not taken; the source holds it.
// TESTING
//  g1 op=5 ra=7 imm=A5, addr 0 -> one write 0x57A5 @0, out_last=1.
//  g2 op=15 ra=3 ra_pair rb=9 -> 0x9569. g3 op=2 ra=5 rbp=3 rcp=6 -> 0xC95E.
//  g5 op=3 ra=2 ra_pair rbp=5 imm=BEEF, out_ready toggling -> 0xE1A5 @n (last=0), then 0xBEEF @n+1 (last=1); data held while stalled; in_ready low until W1 transfer.
//  load 0xFFFF, g4 op=2 imm=3C, then g4 op=0 imm=00 -> 0xD23C @FFFF, then 0xD000 @0000.
//  in_group=0 -> err_group pulse, no out_valid, addr unchanged.
//  reset_n low while W1 held -> out_valid=0 immediately, addr=0, 0xBEEF never written.
//  Back-to-back g1 stream, out_ready=1 -> one word per cycle, addresses consecutive.

Source files
------------

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs decoded instruction fields into 16-bit words and
// streams them, with consecutive addresses, to an instruction-memory write port.
//
// Handshake: a bundle moves on in_valid & in_ready, a word moves on
// out_valid & out_ready; while out_valid is high and out_ready is low the
// out_data/out_addr/out_last outputs are held unchanged.
module instr_stream_encoder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_group,
  input  logic [5:0]        in_opcode,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [2:0]        in_rc,
  input  logic [15:0]       in_imm,
  input  logic              in_ra_pair,
  input  logic              in_rb_pair,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] load_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data,
  output logic              out_last,
  output logic              err_group,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no word held
    W0    = 2'd1,  // single word, or first word of a g5 pair, held
    W1    = 2'd2   // g5 immediate word held
  } state_t;

  state_t            state_q, state_d;
  logic              g5_pending_q, g5_pending_d;
  logic [15:0]       imm_q, imm_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [3:0]  ra_f;
  logic [3:0]  rb_f;
  logic [15:0] word0;
  logic        known;
  logic        accept;
  logic        transfer;

  // Field encoding of the presented bundle (pair indices drop bit 3).
  always_comb begin
    ra_f  = in_ra_pair ? {in_ra[2:0], 1'b0} : in_ra;
    rb_f  = in_rb_pair ? {in_rb[2:0], 1'b0} : in_rb;
    word0 = 16'h0000;
    known = 1'b1;
    case (in_group)
      3'd1:    word0 = {1'b0, in_opcode[2:0], ra_f, in_imm[7:0]};
      3'd2:    word0 = {2'b10, in_opcode, ra_f, rb_f};
      3'd3:    word0 = {4'b1100, in_opcode[1:0], in_ra, in_rb[2:0], in_rc};
      3'd4:    word0 = {4'b1101, in_opcode[3:0], in_imm[7:0]};
      3'd5:    word0 = {4'b1110, 2'b00, in_opcode[2:0], ra_f, in_rb[2:0]};
      default: known = 1'b0;
    endcase
  end

  // Input acceptance: a new bundle may enter whenever the held word is the
  // last one of its instruction and is leaving this cycle.
  always_comb begin
    in_ready = (state_q == EMPTY) ||
               ((state_q == W0) && out_ready && !g5_pending_q) ||
               ((state_q == W1) && out_ready);
    accept   = in_valid && in_ready;
    transfer = out_valid_q && out_ready;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    g5_pending_d = g5_pending_q;
    imm_d        = imm_q;
    out_valid_d  = out_valid_q;
    addr_d       = addr_q;
    data_d       = data_q;
    last_d       = last_q;
    err_d        = 1'b0;

    if (transfer) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if ((state_q == W0) && g5_pending_q) begin
        state_d      = W1;
        g5_pending_d = 1'b0;
        data_d       = imm_q;
        last_d       = 1'b1;
      end else begin
        state_d     = EMPTY;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
      end
    end

    if (accept) begin
      if (known) begin
        state_d      = W0;
        out_valid_d  = 1'b1;
        data_d       = word0;
        last_d       = (in_group != 3'd5);
        g5_pending_d = (in_group == 3'd5);
        imm_d        = in_imm;
      end else begin
        err_d = 1'b1;
      end
    end else if ((state_q == EMPTY) && load_addr) begin
      addr_d = load_value;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      g5_pending_q <= 1'b0;
      imm_q        <= 16'h0000;
      out_valid_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= 16'h0000;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      g5_pending_q <= g5_pending_d;
      imm_q        <= imm_d;
      out_valid_q  <= out_valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      err_q        <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign err_group = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_stream_encoder;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_group = '0;
  logic [5:0]    in_opcode = '0;
  logic [3:0]    in_ra = '0;
  logic [3:0]    in_rb = '0;
  logic [2:0]    in_rc = '0;
  logic [15:0]   in_imm = '0;
  logic          in_ra_pair = 1'b0;
  logic          in_rb_pair = 1'b0;
  logic          load_addr = 1'b0;
  logic [AW-1:0] load_value = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [15:0]   out_data;
  logic          out_last;
  logic          err_group;
  logic [1:0]    dbg_state;

  instr_stream_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_group(in_group), .in_opcode(in_opcode),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm),
    .in_ra_pair(in_ra_pair), .in_rb_pair(in_rb_pair),
    .load_addr(load_addr), .load_value(load_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .err_group(err_group), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: words still to be written, in order
  logic [15:0]   exp_q[$];
  bit            exp_last_q[$];
  logic [AW-1:0] model_addr = '0;
  bit            err_pend = 0;
  int            cyc = 0;

  // log of every observed write
  logic [AW-1:0] log_addr[$];
  logic [15:0]   log_data[$];
  bit            log_last[$];
  int            log_cyc[$];

  bit rand_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int g, input int op, input int ra, input int rb,
                                      input int rc, input int imm, input bit rap, input bit rbp);
    int a;
    int b;
    a = rap ? (ra % 8) * 2 : ra % 16;
    b = rbp ? (rb % 8) * 2 : rb % 16;
    case (g)
      1: return 16'(((op % 8) << 12) + (a << 8) + (imm % 256));
      2: return 16'('h8000 + ((op % 64) << 8) + (a << 4) + b);
      3: return 16'('hC000 + ((op % 4) << 10) + ((ra % 16) << 6) + ((rb % 8) << 3) + (rc % 8));
      4: return 16'('hD000 + ((op % 16) << 8) + (imm % 256));
      5: return 16'('hE000 + ((op % 8) << 7) + (a << 3) + (rb % 8));
      default: return 16'h0000;
    endcase
  endfunction

  // compare process: model vs DUT on every falling edge
  always @(negedge clk) begin
    int  sz;
    bit  exp_rdy;
    bit  acc;
    bit  load_ok;
    cyc++;
    sz = exp_q.size();
    if (!reset_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err_group", err_group, 0);
      exp_q.delete();
      exp_last_q.delete();
      model_addr = '0;
      err_pend = 0;
    end else begin
      exp_rdy = (sz == 0) || (sz == 1 && out_ready);
      chk("out_valid", out_valid, (sz != 0));
      chk("in_ready", in_ready, exp_rdy);
      chk("err_group", err_group, err_pend);
      err_pend = 0;
      if (sz != 0) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, exp_last_q[0]);
        chk("out_addr", out_addr, model_addr);
      end
      if (out_valid && out_ready) begin
        log_addr.push_back(out_addr);
        log_data.push_back(out_data);
        log_last.push_back(out_last);
        log_cyc.push_back(cyc);
      end
      acc = in_valid && exp_rdy;
      load_ok = (sz == 0) && !acc;
      if (sz != 0 && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        model_addr = model_addr + 1'b1;
      end
      if (acc) begin
        if (in_group >= 1 && in_group <= 5) begin
          exp_q.push_back(enc(in_group, in_opcode, in_ra, in_rb, in_rc, in_imm,
                              in_ra_pair, in_rb_pair));
          exp_last_q.push_back(in_group != 5);
          if (in_group == 5) begin
            exp_q.push_back(in_imm);
            exp_last_q.push_back(1'b1);
          end
        end else begin
          err_pend = 1;
        end
      end
      if (load_addr && load_ok) model_addr = load_value;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    load_addr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int g, input int op, input int ra, input int rb, input int rc,
                      input int imm, input bit rap, input bit rbp);
    bit taken;
    int n;
    in_valid = 1'b1;
    in_group = 3'(g);
    in_opcode = 6'(op);
    in_ra = 4'(ra);
    in_rb = 4'(rb);
    in_rc = 3'(rc);
    in_imm = 16'(imm);
    in_ra_pair = rap;
    in_rb_pair = rbp;
    taken = 0;
    n = 0;
    while (!taken && n < 200) begin
      @(negedge clk);
      taken = in_ready;
      tick();
      n++;
    end
    if (!taken) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_log(input int count);
    int n;
    n = 0;
    while (log_data.size() < count && n < 400) begin
      tick();
      n++;
    end
    if (log_data.size() < count) chk("wait_log_timeout", log_data.size(), count);
  endtask

  task automatic chk_log(input string name, input int i, input int addr, input int data,
                         input bit last);
    if (log_data.size() <= i) begin
      chk({name, "_missing"}, log_data.size(), i + 1);
    end else begin
      chk({name, "_addr"}, log_addr[i], addr);
      chk({name, "_data"}, log_data[i], data);
      chk({name, "_last"}, log_last[i], last);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int n;
    // model pins
    chk("enc_g1", enc(1, 5, 7, 0, 0, 'hA5, 0, 0), 16'h57A5);
    chk("enc_g2", enc(2, 'h15, 3, 9, 0, 0, 1, 0), 16'h9569);
    chk("enc_g3", enc(3, 2, 5, 3, 6, 0, 0, 0), 16'hC95E);
    chk("enc_g5", enc(5, 3, 2, 5, 0, 'hBEEF, 1, 0), 16'hE1A5);
    chk("enc_g4", enc(4, 2, 0, 0, 0, 'h3C, 0, 0), 16'hD23C);

    // reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // g1, g2, g3 at addresses 0..2
    out_ready = 1'b1;
    send(1, 5, 7, 0, 0, 'hA5, 0, 0);
    send(2, 'h15, 3, 9, 0, 0, 1, 0);
    send(3, 2, 5, 3, 6, 0, 0, 0);
    idle(3);
    chk_log("g1", 0, 0, 'h57A5, 1);
    chk_log("g2", 1, 1, 'h9569, 1);
    chk_log("g3", 2, 2, 'hC95E, 1);

    // g5 with out_ready toggling
    rand_ready = 1;
    send(5, 3, 2, 5, 0, 'hBEEF, 1, 0);
    in_valid = 1'b0;
    wait_log(5);
    rand_ready = 0;
    out_ready = 1'b1;
    chk_log("g5_hi", 3, 3, 'hE1A5, 0);
    chk_log("g5_imm", 4, 4, 'hBEEF, 1);

    // address load and wrap
    idle(2);
    load_addr = 1'b1;
    load_value = 16'hFFFF;
    tick();
    load_addr = 1'b0;
    send(4, 2, 0, 0, 0, 'h3C, 0, 0);
    send(4, 0, 0, 0, 0, 'h00, 0, 0);
    idle(3);
    chk_log("g4_a", 5, 'hFFFF, 'hD23C, 1);
    chk_log("g4_wrap", 6, 0, 'hD000, 1);

    // unknown group: no write, address unchanged
    n = log_data.size();
    send(0, 1, 2, 3, 4, 5, 0, 0);
    idle(3);
    chk("unk_no_write", log_data.size(), n);
    send(1, 1, 1, 0, 0, 1, 0, 0);
    idle(3);
    chk_log("after_unk", n, 1, 'h1101, 1);

    // reset while the g5 immediate is held
    n = log_data.size();
    out_ready = 1'b0;
    send(5, 3, 2, 5, 0, 'hBEEF, 1, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_addr", out_addr, 0);
    tick();
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    chk("rst_one_write", log_data.size(), n + 1);
    chk_log("rst_hi", n, 2, 'hE1A5, 0);

    // back-to-back g1 stream
    n = log_data.size();
    for (int i = 0; i < 8; i++)
      send(1, $urandom_range(0, 7), $urandom_range(0, 15), 0, 0, $urandom_range(0, 255),
           1'($urandom_range(0, 1)), 0);
    idle(4);
    chk("b2b_count", log_data.size(), n + 8);
    if (log_data.size() >= n + 8) begin
      chk("b2b_first_addr", log_addr[n], 0);
      for (int i = 1; i < 8; i++) begin
        chk("b2b_addr", log_addr[n + i], 16'(log_addr[n] + i));
        chk("b2b_cycle", log_cyc[n + i], log_cyc[n] + i);
      end
    end

    // random traffic
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load_addr = 1'b1;
        load_value = 16'($urandom);
      end
      send($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 65535),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      load_addr = 1'b0;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    rand_ready = 0;
    out_ready = 1'b1;
    idle(10);
    chk("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
